bitstream_generator: RTL and testbench
======================================

Name: bitstream_generator

Overview:
- Converts an unsigned integer into a unipolar stochastic bitstream for the bitstream network.
- Each bit is 1 when a free-running maximal-length LFSR value is at most the latched input. The probability of a 1 is therefore x/(2^WIDTH-1).
- Emits a frame-qualifying capture strobe that brackets exactly LENGTH stream bits, so a downstream bitstream-to-integer counter can accumulate the frame.
- Sits at the network input boundary, feeding bitstream arithmetic.

Parameters:
- WIDTH, 8, bit width of input value and LFSR; legal range 4..16.
- LENGTH, 255, frame length in bits; legal range 1..65535; 2^WIDTH-1 gives an exact ones count.
- SEED, 1, LFSR reset value; must be nonzero modulo 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- x  input  WIDTH  unsigned value to encode; sampled only on start acceptance
- start  input  1  request a frame; accepted only in IDLE
- y  output  1  stream bit; registered
- capture  output  1  high for exactly LENGTH consecutive cycles while y carries frame bits; registered
- busy  output  1  high from the cycle after acceptance until back in IDLE
- done  output  1  one-cycle pulse on the cycle after the last frame bit

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, lfsr=SEED, count=0, value=0.
  - y=0, capture=0, busy=0, done=0.
  - Reset overrides all other inputs. Reset mid-frame aborts the frame with no done pulse.
- LFSR:
  - Fibonacci, maximal-length, period 2^WIDTH-1.
  - Taps come from a fixed per-WIDTH table (WIDTH=8: x^8+x^6+x^5+x^4+1).
  - Steps once per cycle in every state, including IDLE. The stream phase therefore depends on elapsed cycles since reset, not on start.
  - Never reaches 0.
- States IDLE, RUNNING, DONE, with all outputs registered from state:
  - IDLE:
    - y=0, capture=0, busy=0, done=0.
    - If start=1: value<=x, count<=0, next=RUNNING.
  - RUNNING:
    - capture=1, busy=1, and y=(lfsr<=value) using the current-cycle lfsr.
    - count increments each cycle.
    - When count==LENGTH-1: next=DONE. Otherwise stay in RUNNING.
  - DONE:
    - y=0, capture=0, busy=1, done=1.
    - next=IDLE unconditionally.
- Latency:
  - start sampled at edge N drives capture=1 from edge N+1 through edge N+LENGTH.
  - done=1 for the cycle after edge N+LENGTH+1.
  - Back-to-back frames: minimum gap between capture windows is 2 cycles (DONE, IDLE).
- Input handling:
  - start while busy=1 is ignored, not queued.
  - x changes during a frame have no effect.
- Arithmetic:
  - Compare is unsigned, WIDTH bits.
  - count width is $clog2(LENGTH+1).
- Exactness:
  - With LENGTH=2^WIDTH-1, a frame covers one full LFSR period from any phase.
  - The ones count then equals value exactly: x=0 gives all zeros, x=2^WIDTH-1 gives all ones.
  - For other LENGTH values the ones count is approximate.
- LENGTH=1: one RUNNING cycle, then DONE.

Test Plan:
- Reset, idle 10 cycles -> y=0, capture=0, busy=0, done=0 throughout; no spurious done.
- WIDTH=8, LENGTH=255: start with x=0, x=255, x=128, x=37 in turn -> capture high exactly 255 cycles per frame; ones counted under capture = 0, 255, 128, 37; done pulses once per frame, 1 cycle after capture falls.
- start held high continuously, x toggling during frames -> frames repeat with a 2-cycle gap; each frame's count matches the x sampled on acceptance cycle only.
- rst asserted at cycle 100 of a frame -> next cycle all outputs 0, state IDLE, no done; new start then produces a full 255-bit frame.
- LENGTH=1, x=255 -> capture high 1 cycle with y=1; done pulses on the following cycle.
- LENGTH=16, x=128, repeated 1000 frames -> mean ones per frame within 8±0.5; LFSR never observed at 0.

Source files
------------

// File: rtl/bitstream_generator.sv
// bitstream_generator
// Encodes an unsigned WIDTH-bit value as a unipolar stochastic bitstream.
// A free-running maximal-length Fibonacci LFSR is compared against the
// value latched at frame start; each frame emits exactly LENGTH stream
// bits qualified by a capture strobe, followed by a one-cycle done pulse.
// All outputs are registered from the current state, so they trail the
// state register by one cycle.
module bitstream_generator #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 255,
    parameter int SEED   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             start,
    output logic             y,
    output logic             capture,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(LENGTH + 1);

    // Feedback tap masks for maximal-length sequences, bit i set means
    // LFSR bit i participates in the feedback XOR.
    function automatic logic [15:0] tap_mask(input int w);
        logic [15:0] m;
        case (w)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h00B8;
        endcase
        return m;
    endfunction

    localparam logic [15:0]      TAPS_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
    localparam logic [CW-1:0]    LAST      = CW'(LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_next;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_next;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;

    logic             r_y;
    logic             r_capture;
    logic             r_busy;
    logic             r_done;
    logic             w_y_next;
    logic             w_capture_next;
    logic             w_busy_next;
    logic             w_done_next;

    logic [WIDTH-1:0] w_tap_bits;
    logic             w_feedback;

    // Mask each LFSR bit with its tap enable; the XOR reduction of the
    // masked bits forms the Fibonacci feedback.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
            assign w_tap_bits[gi] = r_lfsr[gi] & TAPS[gi];
        end
    endgenerate

    assign w_feedback  = ^w_tap_bits;
    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], w_feedback};

    // LFSR steps every cycle regardless of state, so stream phase is tied
    // to cycles since reset rather than to frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED_W;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Next-state, datapath and registered-output decode from current state.
    always_comb begin
        w_state_next   = r_state;
        w_value_next   = r_value;
        w_count_next   = r_count;
        w_y_next       = 1'b0;
        w_capture_next = 1'b0;
        w_busy_next    = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_value_next = x;
                    w_count_next = '0;
                    w_state_next = S_RUNNING;
                end
            end
            S_RUNNING: begin
                w_capture_next = 1'b1;
                w_busy_next    = 1'b1;
                w_y_next       = (r_lfsr <= r_value);
                w_count_next   = r_count + 1'b1;
                if (r_count == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy_next  = 1'b1;
                w_done_next  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_value <= w_value_next;
            r_count <= w_count_next;
        end
    end

    // Output registers, one cycle behind the state they are decoded from.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= 1'b0;
            r_capture <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_y       <= w_y_next;
            r_capture <= w_capture_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign y       = r_y;
    assign capture = r_capture;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_bitstream_generator.sv
// tb_bitstream_generator
// Three instances: the main 8-bit/255 frame generator checked every cycle
// against a frame-timeline model, a LENGTH=1 instance and a LENGTH=16
// instance used for the short-frame and statistical checks.
module tb_bitstream_generator;

    localparam int L_MAIN = 255;

    logic       clk;
    logic       rst;
    logic [7:0] x_m, x_1, x_16;
    logic       start_m, start_1, start_16;
    logic       y_m, cap_m, busy_m, done_m;
    logic       y_1, cap_1, busy_1, done_1;
    logic       y_16, cap_16, busy_16, done_16;

    int total = 0;
    int bad   = 0;

    bitstream_generator #(.WIDTH(8), .LENGTH(L_MAIN), .SEED(1)) u_main (
        .clk(clk), .rst(rst), .x(x_m), .start(start_m),
        .y(y_m), .capture(cap_m), .busy(busy_m), .done(done_m)
    );

    bitstream_generator #(.WIDTH(8), .LENGTH(1), .SEED(1)) u_len1 (
        .clk(clk), .rst(rst), .x(x_1), .start(start_1),
        .y(y_1), .capture(cap_1), .busy(busy_1), .done(done_1)
    );

    bitstream_generator #(.WIDTH(8), .LENGTH(16), .SEED(1)) u_len16 (
        .clk(clk), .rst(rst), .x(x_16), .start(start_16),
        .y(y_16), .capture(cap_16), .busy(busy_16), .done(done_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-timeline model of the main instance: k counts clock edges since
    // the accepting edge. Capture spans k=1..L, busy k=1..L+1, done at k=L+1,
    // and a new start can be accepted from k=L+2 onwards.
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_value  = 0;
    bit exp_cap  = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
        end else begin
            if (m_active) m_k++;
            if (!m_active || m_k >= L_MAIN + 2) begin
                if (start_m) begin
                    m_active = 1'b1;
                    m_k      = 0;
                    m_value  = int'(x_m);
                end else begin
                    m_active = 1'b0;
                end
            end
        end
        exp_cap  = m_active && m_k >= 1 && m_k <= L_MAIN;
        exp_busy = m_active && m_k >= 1 && m_k <= L_MAIN + 1;
        exp_done = m_active && m_k == L_MAIN + 1;
    end

    // Per-cycle comparison of the main instance against the model; the
    // ones count of each full frame must equal the latched value exactly.
    int acc = 0;
    always @(negedge clk) begin
        chk("main_cap_busy_done", int'({cap_m, busy_m, done_m}),
            int'({exp_cap, exp_busy, exp_done}));
        if (exp_cap) begin
            if (m_k == 1) acc = int'(y_m);
            else          acc = acc + int'(y_m);
        end else begin
            chk("main_y_outside_frame", int'(y_m), 0);
        end
        if (exp_done) chk("main_frame_ones_model", acc, m_value);
    end

    // One directed frame on the main instance with x scrambled mid-frame.
    task automatic run_main(input int v);
        int caps, ones;
        bit seen;
        caps = 0; ones = 0; seen = 1'b0;
        x_m = 8'(v);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            x_m = 8'($urandom);
            if (cap_m) begin caps++; ones += int'(y_m); end
            if (done_m) seen = 1'b1;
        end
        chk("main_done_seen", int'(seen), 1);
        chk("main_capture_len", caps, 255);
        chk("main_ones_literal", ones, v);
        @(negedge clk);
        chk("main_done_single", int'(done_m), 0);
        $display("frame x=%0d capture=%0d ones=%0d", v, caps, ones);
    endtask

    initial begin
        int sum16;
        rst = 1'b1;
        x_m = '0; x_1 = '0; x_16 = '0;
        start_m = 1'b0; start_1 = 1'b0; start_16 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: every output low.
        repeat (10) @(negedge clk);
        chk("idle_outputs", int'({y_m, cap_m, busy_m, done_m}), 0);

        // Directed frames, exact ones count over a full LFSR period.
        run_main(0);
        run_main(255);
        run_main(128);
        run_main(37);

        // Start held high with x toggling every cycle: frames repeat with a
        // two-cycle gap and use only the value sampled at acceptance.
        start_m = 1'b1;
        for (int i = 0; i < 5 * 257 + 3; i++) begin
            @(negedge clk);
            x_m = 8'($urandom);
        end
        start_m = 1'b0;
        repeat (300) @(negedge clk);

        // Reset in the middle of a frame aborts it without a done pulse.
        x_m = 8'd200;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_mid_frame_outputs", int'({y_m, cap_m, busy_m, done_m}), 0);
        repeat (5) @(negedge clk);
        run_main(91);

        // Random starts, values and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start_m = ($urandom_range(0, 9) == 0);
            x_m     = 8'($urandom);
            rst     = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
        start_m = 1'b0;
        repeat (300) @(negedge clk);

        // LENGTH=1: a single capture cycle, then done.
        for (int j = 0; j < 2; j++) begin
            x_1 = (j == 0) ? 8'd255 : 8'd0;
            start_1 = 1'b1;
            @(negedge clk);
            start_1 = 1'b0;
            @(negedge clk);
            chk("len1_capture", int'(cap_1), 1);
            chk("len1_y", int'(y_1), (j == 0) ? 1 : 0);
            chk("len1_done_early", int'(done_1), 0);
            @(negedge clk);
            chk("len1_capture_off", int'(cap_1), 0);
            chk("len1_done", int'(done_1), 1);
            @(negedge clk);
            chk("len1_done_single", int'(done_1), 0);
            $display("len1 frame x=%0d", x_1);
        end

        // LENGTH=16, x=128 over 1000 frames at varied phases: the mean ones
        // count must sit within 8 +/- 0.5.
        sum16 = 0;
        for (int f = 0; f < 1000; f++) begin
            int caps, ones;
            bit seen;
            caps = 0; ones = 0; seen = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x_16 = 8'd128;
            start_16 = 1'b1;
            @(negedge clk);
            start_16 = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (cap_16) begin caps++; ones += int'(y_16); end
                if (done_16) seen = 1'b1;
            end
            chk("len16_done_seen", int'(seen), 1);
            chk("len16_capture_len", caps, 16);
            sum16 += ones;
        end
        chk("len16_mean_in_range", int'(sum16 >= 7500 && sum16 <= 8500), 1);
        $display("len16 1000 frames ones_total=%0d", sum16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
